// File: rtl/pm_seq_if.sv
// pm_seq_if: operand (in_*) and result (out_*) valid/ready channels of the pm sequencer.
// The master drives operands and result acceptance; the slave is the sequencer.
interface pm_seq_if #(
  parameter int SIZE = 32
);

  logic              in_valid;
  logic              in_ready;
  logic [SIZE-1:0]   in_a;
  logic [SIZE-1:0]   in_b;
  logic              out_valid;
  logic              out_ready;
  logic [2*SIZE-1:0] out_p;
  logic              out_err;

  modport master (
    output in_valid,
    output in_a,
    output in_b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_p,
    input  out_err
  );

  modport slave (
    input  in_valid,
    input  in_a,
    input  in_b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_p,
    output out_err
  );

endinterface

// File: rtl/pm_seq.sv
// pm_seq: one-at-a-time sequencer feeding a serial-parallel multiplier (pm) and returning its product.
// Build macro PM_SIGNED_EN: two's-complement operands; pm sees magnitudes, the sign is re-applied to the product.
module pm_seq #(
  parameter int SIZE = 32,
  parameter int TMO  = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  pm_seq_if.slave           s_if,
  output logic              o_pm_start,
  output logic [SIZE-1:0]   o_pm_mc,
  output logic [SIZE-1:0]   o_pm_mp,
  input  logic [2*SIZE-1:0] i_pm_p,
  input  logic              i_pm_done
);

  // Timeout fires at the end of the TMO-th WAIT cycle, so the counter compares against TMO-1.
  localparam logic [15:0] TMO_LAST = 16'(TMO - 1);

  // state   | meaning
  // S_IDLE  | ready for an operand pair
  // S_ISSUE | one-cycle pm start pulse, timeout counter cleared
  // S_WAIT  | waiting for pm done or timeout
  // S_HOLD  | result presented until the consumer takes it
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [SIZE-1:0]   r_mc;
  logic [SIZE-1:0]   r_mp;
  logic [15:0]       r_cnt;
  logic [2*SIZE-1:0] r_p;
  logic              r_err;

  logic              w_accept;
  logic              w_start;
  logic              w_take;
  logic              w_tmo;
  logic              w_in_ready;
  logic              w_out_valid;
  logic [SIZE-1:0]   w_mag_a;
  logic [SIZE-1:0]   w_mag_b;
  logic [2*SIZE-1:0] w_res;

`ifdef PM_SIGNED_EN
  logic r_neg;

  // Unary minus maps -2^(SIZE-1) onto itself, which reads correctly as the unsigned magnitude.
  assign w_mag_a = s_if.in_a[SIZE-1] ? -s_if.in_a : s_if.in_a;
  assign w_mag_b = s_if.in_b[SIZE-1] ? -s_if.in_b : s_if.in_b;
  assign w_res   = r_neg ? -i_pm_p : i_pm_p;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_neg <= 1'b0;
    end else if (w_accept) begin
      r_neg <= s_if.in_a[SIZE-1] ^ s_if.in_b[SIZE-1];
    end
  end
`else
  assign w_mag_a = s_if.in_a;
  assign w_mag_b = s_if.in_b;
  assign w_res   = i_pm_p;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_start     = 1'b0;
    w_take      = 1'b0;
    w_tmo       = 1'b0;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (s_if.in_valid) begin
          w_accept = 1'b1;
          w_next   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_start = 1'b1;
        w_next  = S_WAIT;
      end
      S_WAIT: begin
        // A done arriving together with the timeout still yields a real result.
        if (i_pm_done) begin
          w_take = 1'b1;
          w_next = S_HOLD;
        end else if (r_cnt == TMO_LAST) begin
          w_tmo  = 1'b1;
          w_next = S_HOLD;
        end
      end
      S_HOLD: begin
        w_out_valid = 1'b1;
        if (s_if.out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mc  <= '0;
      r_mp  <= '0;
      r_cnt <= '0;
      r_p   <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mc <= w_mag_a;
        r_mp <= w_mag_b;
      end
      if (w_start) begin
        r_cnt <= '0;
      end else if (r_state == S_WAIT && !i_pm_done) begin
        r_cnt <= r_cnt + 16'd1;
      end
      if (w_take) begin
        r_p   <= w_res;
        r_err <= 1'b0;
      end else if (w_tmo) begin
        r_p   <= '0;
        r_err <= 1'b1;
      end
    end
  end

  assign o_pm_start     = w_start;
  assign o_pm_mc        = r_mc;
  assign o_pm_mp        = r_mp;
  assign s_if.in_ready  = w_in_ready;
  assign s_if.out_valid = w_out_valid;
  assign s_if.out_p     = r_p;
  assign s_if.out_err   = r_err;

endmodule

// File: tb/tb_pm_seq.sv
// tb_pm_seq: randomized and directed operations against pm_seq with a behavioural pm model;
// results and timing are predicted from arithmetic and the published latency rules.
module tb_pm_seq;

  localparam int SIZE = 32;
  localparam int TMO  = 100;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              pm_start;
  logic [SIZE-1:0]   pm_mc;
  logic [SIZE-1:0]   pm_mp;
  logic [2*SIZE-1:0] pm_p;
  logic              pm_done;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int pm_mode = 0; // 0 conforming pm, 1 done tied low, 2 done tied high

  pm_seq_if #(.SIZE(SIZE)) u_if ();

  pm_seq #(.SIZE(SIZE), .TMO(TMO)) u_dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .s_if       (u_if),
    .o_pm_start (pm_start),
    .o_pm_mc    (pm_mc),
    .o_pm_mp    (pm_mp),
    .i_pm_p     (pm_p),
    .i_pm_done  (pm_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural pm: product ready and done raised 2*SIZE+2 cycles after the start cycle.
  int   pm_cnt = 0;
  logic pm_done_r = 1'b0;
  logic [2*SIZE-1:0] pm_p_r = '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pm_cnt    <= 0;
      pm_done_r <= 1'b0;
      pm_p_r    <= '0;
    end else if (pm_start) begin
      pm_p_r    <= {32'b0, pm_mc} * {32'b0, pm_mp};
      pm_cnt    <= 2*SIZE + 1;
      pm_done_r <= 1'b0;
    end else if (pm_cnt != 0) begin
      pm_cnt <= pm_cnt - 1;
      if (pm_cnt == 1) pm_done_r <= 1'b1;
    end
  end

  assign pm_p    = pm_p_r;
  assign pm_done = (pm_mode == 1) ? 1'b0 : (pm_mode == 2) ? 1'b1 : pm_done_r;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [63:0] p, output logic [31:0] ma,
                                output logic [31:0] mb);
`ifdef PM_SIGNED_EN
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = 64'(sa * sb);
    ma = 32'(sa < 0 ? -sa : sa);
    mb = 32'(sb < 0 ? -sb : sb);
`else
    p  = {32'b0, a} * {32'b0, b};
    ma = a;
    mb = b;
`endif
  endfunction

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int mode, input int bp);
    logic [63:0] exp_p;
    logic [31:0] exp_mc;
    logic [31:0] exp_mp;
    logic        exp_err;
    int          exp_lat;
    int          t_acc;
    int          n;
    int          starts;
    int          bad;
    model(a, b, exp_p, exp_mc, exp_mp);
    exp_err = 1'b0;
    exp_lat = 2*SIZE + 4;
    if (mode == 1) begin
      exp_p   = '0;
      exp_err = 1'b1;
      exp_lat = TMO + 2;
    end else if (mode == 2) begin
      exp_lat = 3;
    end
    @(negedge clk);
    pm_mode        = mode;
    u_if.in_valid  = 1'b1;
    u_if.in_a      = a;
    u_if.in_b      = b;
    u_if.out_ready = (bp == 0);
    n = 0;
    while (!u_if.in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", {63'b0, u_if.in_ready}, 64'd1);
    t_acc = cyc;
    @(negedge clk);
    u_if.in_valid = 1'b0;
    starts = int'(pm_start);
    bad = 0;
    n = 0;
    while (!u_if.out_valid && n < 400) begin
      if (u_if.in_ready) bad++;
      @(negedge clk);
      starts += int'(pm_start);
      n++;
    end
    chk("out_valid_seen", {63'b0, u_if.out_valid}, 64'd1);
    chk("latency", 64'(cyc - t_acc), 64'(exp_lat));
    chk("out_p", u_if.out_p, exp_p);
    chk("out_err", {63'b0, u_if.out_err}, {63'b0, exp_err});
    chk("pm_mc", {32'b0, pm_mc}, {32'b0, exp_mc});
    chk("pm_mp", {32'b0, pm_mp}, {32'b0, exp_mp});
    chk("start_pulses", 64'(starts), 64'd1);
    chk("in_ready_busy", 64'(bad), 64'd0);
    if (bp > 0) begin
      // A second operand pair is offered during backpressure and must not be taken.
      u_if.in_valid = 1'b1;
      u_if.in_a     = ~a;
      u_if.in_b     = ~b;
      bad = 0;
      repeat (bp) begin
        @(negedge clk);
        if (!u_if.out_valid || u_if.in_ready || u_if.out_p !== exp_p ||
            pm_mc !== exp_mc || pm_start) bad++;
      end
      chk("backpressure_hold", 64'(bad), 64'd0);
      u_if.in_valid  = 1'b0;
      u_if.out_ready = 1'b1;
    end
    @(negedge clk);
    chk("out_valid_drop", {63'b0, u_if.out_valid}, 64'd0);
    chk("in_ready_back", {63'b0, u_if.in_ready}, 64'd1);
  endtask

  task automatic reset_mid_wait(input int depth);
    @(negedge clk);
    pm_mode        = 0;
    u_if.in_valid  = 1'b1;
    u_if.in_a      = 32'h11;
    u_if.in_b      = 32'h22;
    u_if.out_ready = 1'b1;
    @(negedge clk);
    u_if.in_valid = 1'b0;
    repeat (depth + 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_out_valid", {63'b0, u_if.out_valid}, 64'd0);
    chk("rst_in_ready", {63'b0, u_if.in_ready}, 64'd1);
    chk("rst_pm_mc", {32'b0, pm_mc}, 64'd0);
    chk("rst_out_p", u_if.out_p, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int          rm;
    u_if.in_valid  = 1'b0;
    u_if.in_a      = '0;
    u_if.in_b      = '0;
    u_if.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", {63'b0, u_if.in_ready}, 64'd1);
    chk("reset_out_valid", {63'b0, u_if.out_valid}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready_after", {63'b0, u_if.in_ready}, 64'd1);
    chk("reset_out_p", u_if.out_p, 64'd0);
    chk("reset_out_err", {63'b0, u_if.out_err}, 64'd0);
    chk("reset_pm_start", {63'b0, pm_start}, 64'd0);
    chk("reset_pm_mc", {32'b0, pm_mc}, 64'd0);
    chk("reset_pm_mp", {32'b0, pm_mp}, 64'd0);

    do_op(32'd3, 32'd5, 0, 0);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    do_op(32'd0, 32'h1234_5678, 0, 0);
    do_op(32'd9, 32'd9, 0, 20);
    do_op(32'd123, 32'd456, 0, 0);
    do_op(32'd77, 32'd88, 1, 0);
    do_op(32'd77, 32'd88, 2, 3);
    reset_mid_wait(30);
    do_op(32'd7, 32'd6, 0, 0);
    do_op(32'hFFFF_FFFD, 32'd5, 0, 0);
    do_op(32'h8000_0000, 32'h8000_0000, 0, 0);

    for (int i = 0; i < 12; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 9))
        0: ra = 32'h0;
        1: rb = 32'hFFFF_FFFF;
        2: ra = 32'h8000_0000;
        default: ;
      endcase
      case ($urandom_range(0, 7))
        0: rm = 1;
        1: rm = 2;
        default: rm = 0;
      endcase
      do_op(ra, rb, rm, $urandom_range(0, 4));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
